axi_lite_rd_arbiter: RTL and testbench

AXI_LITE_RD_ARBITER -- requirements
Module: axi_lite_rd_arbiter

---
 rtl/axi_lite_arb_pkg.sv | 17 +
 rtl/axi_lite_rr_arb.sv | 19 +
 rtl/axi_lite_rd_arbiter.sv | 165 ++++++++++++++++
 tb/tb_axi_lite_rd_arbiter.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the two-requester AXI-Lite read arbiter.
package axi_lite_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StResp = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Index of a requester: 0 = s0, 1 = s1.
    typedef logic grant_t;

endpackage

// File: rtl/axi_lite_rr_arb.sv
// Two-way round-robin pick: contention goes to the requester not granted last.
module axi_lite_rr_arb
    import axi_lite_arb_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    output grant_t     grant
);

    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// Arbitrates two AXI-Lite read requesters onto one slave, one transaction at a time.
// Optional watchdog on the slave side: define AXI_LITE_RD_ARB_TIMEOUT_EN.
module axi_lite_rd_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,
    input  logic              s0_axi_arvalid,
    output logic              s0_axi_arready,
    input  logic [ADDR_W-1:0] s0_axi_araddr,
    output logic              s0_axi_rvalid,
    input  logic              s0_axi_rready,
    output logic [DATA_W-1:0] s0_axi_rdata,
    output logic [1:0]        s0_axi_rresp,
    input  logic              s1_axi_arvalid,
    output logic              s1_axi_arready,
    input  logic [ADDR_W-1:0] s1_axi_araddr,
    output logic              s1_axi_rvalid,
    input  logic              s1_axi_rready,
    output logic [DATA_W-1:0] s1_axi_rdata,
    output logic [1:0]        s1_axi_rresp,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    output logic              o_busy,
    output logic              o_grant
);

    arb_state_e        state_q, state_d;
    grant_t            owner_q, owner_d;
    grant_t            last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    grant_t            winner;
    logic              timeout;
    logic              owner_rready;

    axi_lite_rr_arb u_rr_arb (
        .req        ({s1_axi_arvalid, s0_axi_arvalid}),
        .last_grant (last_q),
        .grant      (winner)
    );

`ifdef AXI_LITE_RD_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    // Idle clears the count so every ADDR entry starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StAddr || state_q == StData) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == StAddr || state_q == StData) &&
                     (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign owner_rready = owner_q ? s1_axi_rready : s0_axi_rready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        case (state_q)
            StIdle: begin
                if (s0_axi_arvalid || s1_axi_arvalid) begin
                    owner_d = winner;
                    addr_d  = winner ? s1_axi_araddr : s0_axi_araddr;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (m_axi_arready) begin
                    state_d = StData;
                end else if (timeout) begin
                    rdata_d = '0;
                    rresp_d = RESP_DECERR;
                    state_d = StResp;
                end
            end
            StData: begin
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    rresp_d = m_axi_rresp;
                    state_d = StResp;
                end else if (timeout) begin
                    rdata_d = '0;
                    rresp_d = RESP_DECERR;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (owner_rready) begin
                    last_d  = owner_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // last_q resets to s1 so the first contended grant goes to s0.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

    // arready is gated by reset so a requester holding arvalid sees 0 while in reset.
    assign s0_axi_arready = m_axi_aresetn && (state_q == StIdle) && s0_axi_arvalid && !winner;
    assign s1_axi_arready = m_axi_aresetn && (state_q == StIdle) && s1_axi_arvalid && winner;

    assign m_axi_arvalid = (state_q == StAddr);
    assign m_axi_araddr  = m_axi_arvalid ? addr_q : '0;
    assign m_axi_rready  = (state_q == StData);

    assign s0_axi_rvalid = (state_q == StResp) && !owner_q;
    assign s1_axi_rvalid = (state_q == StResp) && owner_q;
    assign s0_axi_rdata  = s0_axi_rvalid ? rdata_q : '0;
    assign s1_axi_rdata  = s1_axi_rvalid ? rdata_q : '0;
    assign s0_axi_rresp  = s0_axi_rvalid ? rresp_q : RESP_OKAY;
    assign s1_axi_rresp  = s1_axi_rvalid ? rresp_q : RESP_OKAY;

    assign o_busy  = (state_q != StIdle);
    assign o_grant = owner_q;

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed self-checking bench for axi_lite_rd_arbiter with a behavioural slave (mem[i] = i*5).
module tb_axi_lite_rd_arbiter;

    logic        clk;
    logic        rst_n;
    logic        s0_arvalid, s1_arvalid;
    logic        s0_arready, s1_arready;
    logic [31:0] s0_araddr, s1_araddr;
    logic        s0_rvalid, s1_rvalid;
    logic        s0_rready, s1_rready;
    logic [31:0] s0_rdata, s1_rdata;
    logic [1:0]  s0_rresp, s1_rresp;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic        m_rvalid, m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        busy, grant;

    logic        slave_dead, r_stall, pend;
    logic [31:0] paddr;
    int          total, bad;

    axi_lite_rd_arbiter dut (
        .m_axi_aclk     (clk),
        .m_axi_aresetn  (rst_n),
        .s0_axi_arvalid (s0_arvalid),
        .s0_axi_arready (s0_arready),
        .s0_axi_araddr  (s0_araddr),
        .s0_axi_rvalid  (s0_rvalid),
        .s0_axi_rready  (s0_rready),
        .s0_axi_rdata   (s0_rdata),
        .s0_axi_rresp   (s0_rresp),
        .s1_axi_arvalid (s1_arvalid),
        .s1_axi_arready (s1_arready),
        .s1_axi_araddr  (s1_araddr),
        .s1_axi_rvalid  (s1_rvalid),
        .s1_axi_rready  (s1_rready),
        .s1_axi_rdata   (s1_rdata),
        .s1_axi_rresp   (s1_rresp),
        .m_axi_arvalid  (m_arvalid),
        .m_axi_arready  (m_arready),
        .m_axi_araddr   (m_araddr),
        .m_axi_rvalid   (m_rvalid),
        .m_axi_rready   (m_rready),
        .m_axi_rdata    (m_rdata),
        .m_axi_rresp    (m_rresp),
        .o_busy         (busy),
        .o_grant        (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: always ready for addresses unless dead; data returned the cycle after the AR handshake.
    assign m_arready = !slave_dead;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rvalid <= 1'b0;
            m_rdata  <= '0;
            m_rresp  <= 2'b00;
            pend     <= 1'b0;
            paddr    <= '0;
        end else begin
            if (m_rvalid && m_rready) begin
                m_rvalid <= 1'b0;
            end else if (!m_rvalid && !r_stall && (pend || (m_arvalid && m_arready))) begin
                m_rvalid <= 1'b1;
                m_rdata  <= mem_of(pend ? paddr : m_araddr);
                m_rresp  <= ((pend ? paddr : m_araddr) < 16) ? 2'b00 : 2'b11;
                pend     <= 1'b0;
            end else if (m_arvalid && m_arready) begin
                pend  <= 1'b1;
                paddr <= m_araddr;
            end
        end
    end

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return (a < 16) ? a * 5 : 32'd0;
    endfunction

    function automatic logic arready_of(input int p);
        return (p == 0) ? s0_arready : s1_arready;
    endfunction

    function automatic logic rvalid_of(input int p);
        return (p == 0) ? s0_rvalid : s1_rvalid;
    endfunction

    function automatic logic other_nonzero(input int p);
        if (p == 0) return s1_arready || s1_rvalid || (s1_rdata != 0) || (s1_rresp != 0);
        return s0_arready || s0_rvalid || (s0_rdata != 0) || (s0_rresp != 0);
    endfunction

    task automatic set_req(input int p, input logic v, input logic [31:0] a);
        if (p == 0) begin
            s0_arvalid = v;
            s0_araddr  = a;
        end else begin
            s1_arvalid = v;
            s1_araddr  = a;
        end
    endtask

    // One read on port p; returns data/resp, cycles from grant sample to rvalid sample.
    task automatic single_read(input int p, input logic [31:0] a, output logic [31:0] d,
                               output logic [1:0] r, output int lat, output bit ok,
                               output bit quiet);
        bit granted;
        granted = 0;
        ok = 0;
        quiet = 1;
        lat = 0;
        d = '0;
        r = '0;
        @(negedge clk);
        if (p == 0) s0_rready = 1'b1; else s1_rready = 1'b1;
        set_req(p, 1'b1, a);
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            if (other_nonzero(p)) quiet = 0;
            if (!granted && arready_of(p)) begin
                granted = 1;
            end else if (granted && rvalid_of(p)) begin
                d  = (p == 0) ? s0_rdata : s1_rdata;
                r  = (p == 0) ? s0_rresp : s1_rresp;
                ok = 1;
            end
            @(negedge clk);
            if (granted) begin
                set_req(p, 1'b0, '0);
                if (!ok) lat++;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        s0_arvalid = 1'b1;
        s0_araddr  = 32'd3;
        #1;
        total++;
        if (s0_arready !== 1'b0 || s1_arready !== 1'b0) begin
            bad++;
            $display("FAIL reset_arready: got %b%b want 00", s0_arready, s1_arready);
        end
        total++;
        if ({busy, grant, m_arvalid, m_rready, s0_rvalid, s1_rvalid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {busy, grant, m_arvalid, m_rready, s0_rvalid, s1_rvalid});
        end
        total++;
        if ({m_araddr, s0_rdata, s1_rdata, s0_rresp, s1_rresp} !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h %h %h want 0", m_araddr, s0_rdata, s1_rdata);
        end
        @(negedge clk);
        s0_arvalid = 1'b0;
        rst_n = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        bit          ok, quiet;
        single_read(0, 32'd3, d, r, lat, ok, quiet);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_done: got no response want response");
        end
        total++;
        if (d !== 32'd15 || r !== 2'b00) begin
            bad++;
            $display("FAIL single_data: got %0d/%b want 15/00", d, r);
        end
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL single_latency: got %0d want 3", lat);
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL single_s1_quiet: got nonzero s1 outputs want all 0");
        end
        #1;
        total++;
        if (busy !== 1'b0 || s0_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: got busy=%b rvalid=%b want 0 0", busy, s0_rvalid);
        end
    endtask

    task automatic test_decerr;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        bit          ok, quiet;
        single_read(1, 32'd20, d, r, lat, ok, quiet);
        total++;
        if (!ok || r !== 2'b11 || d !== 32'd0) begin
            bad++;
            $display("FAIL decerr: got ok=%0d %0d/%b want 1 0/11", ok, d, r);
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL decerr_s0_quiet: got nonzero s0 outputs want all 0");
        end
    endtask

    task automatic test_round_robin;
        int          ord[4];
        logic [31:0] got0[2], got1[2];
        int          n_ord, rem0, rem1, nr0, nr1;
        n_ord = 0; rem0 = 2; rem1 = 2; nr0 = 0; nr1 = 0;
        for (int k = 0; k < 4; k++) ord[k] = -1;
        got0[0] = '1; got0[1] = '1; got1[0] = '1; got1[1] = '1;
        // Fresh reset so the pointer favours s0.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        s0_rready = 1'b1;
        s1_rready = 1'b1;
        s0_araddr = 32'd2;
        s1_araddr = 32'd7;
        for (int i = 0; i < 80 && (nr0 < 2 || nr1 < 2); i++) begin
            s0_arvalid = (rem0 > 0);
            s1_arvalid = (rem1 > 0);
            #1;
            if (s0_arready) begin
                if (n_ord < 4) ord[n_ord] = 0;
                n_ord++;
                rem0--;
            end
            if (s1_arready) begin
                if (n_ord < 4) ord[n_ord] = 1;
                n_ord++;
                rem1--;
            end
            if (s0_rvalid) begin
                if (nr0 < 2) got0[nr0] = s0_rdata;
                nr0++;
            end
            if (s1_rvalid) begin
                if (nr1 < 2) got1[nr1] = s1_rdata;
                nr1++;
            end
            @(negedge clk);
        end
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        total++;
        if (n_ord !== 4) begin
            bad++;
            $display("FAIL rr_grant_count: got %0d want 4", n_ord);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (ord[k] !== (k % 2)) begin
                bad++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", k, ord[k], k % 2);
            end
        end
        total++;
        if (got0[0] !== 32'd10 || got0[1] !== 32'd10) begin
            bad++;
            $display("FAIL rr_s0_data: got %0d,%0d want 10,10", got0[0], got0[1]);
        end
        total++;
        if (got1[0] !== 32'd35 || got1[1] !== 32'd35) begin
            bad++;
            $display("FAIL rr_s1_data: got %0d,%0d want 35,35", got1[0], got1[1]);
        end
    endtask

    task automatic test_hold;
        bit seen;
        @(negedge clk);
        s1_rready = 1'b0;
        s0_rready = 1'b1;
        set_req(1, 1'b1, 32'd6);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (s1_arready) seen = 1;
            @(negedge clk);
        end
        set_req(1, 1'b0, '0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (s1_rvalid) seen = 1;
            else @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL hold_rvalid: got no s1 rvalid want rvalid");
            return;
        end
        // s0 requests while s1 stalls its response; it must wait.
        set_req(0, 1'b1, 32'd1);
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (s1_rvalid !== 1'b1 || s1_rdata !== 32'd30 || s1_rresp !== 2'b00) begin
                bad++;
                $display("FAIL hold_stable[%0d]: got %b/%0d/%b want 1/30/00",
                         k, s1_rvalid, s1_rdata, s1_rresp);
            end
            total++;
            if (m_arvalid !== 1'b0 || s0_arready !== 1'b0) begin
                bad++;
                $display("FAIL hold_no_new_ar[%0d]: got m_arvalid=%b s0_arready=%b want 0 0",
                         k, m_arvalid, s0_arready);
            end
            @(negedge clk);
        end
        s1_rready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (s1_rvalid !== 1'b0 || s0_arready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: got s1_rvalid=%b s0_arready=%b want 0 1",
                     s1_rvalid, s0_arready);
        end
        @(negedge clk);
        set_req(0, 1'b0, '0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (s0_rvalid) begin
                seen = 1;
                total++;
                if (s0_rdata !== 32'd5) begin
                    bad++;
                    $display("FAIL hold_waiter_data: got %0d want 5", s0_rdata);
                end
            end
            @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL hold_waiter_served: got no s0 rvalid want rvalid");
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        bit          ok, quiet, seen;
        // Leave the pointer favouring s1, then abort an s1 read in DATA.
        single_read(0, 32'd4, d, r, lat, ok, quiet);
        total++;
        if (!ok || d !== 32'd20) begin
            bad++;
            $display("FAIL rmid_pre_read: got ok=%0d %0d want 1 20", ok, d);
        end
        r_stall = 1'b1;
        set_req(1, 1'b1, 32'd9);
        #1;
        total++;
        if (s1_arready !== 1'b1) begin
            bad++;
            $display("FAIL rmid_s1_grant: got %b want 1", s1_arready);
        end
        @(negedge clk);
        set_req(1, 1'b0, '0);
        @(negedge clk);
        #1;
        total++;
        if (m_rready !== 1'b1 || busy !== 1'b1 || grant !== 1'b1) begin
            bad++;
            $display("FAIL rmid_in_data: got rready=%b busy=%b grant=%b want 1 1 1",
                     m_rready, busy, grant);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, grant, m_arvalid, m_rready, s0_arready, s1_arready, s0_rvalid, s1_rvalid}
            !== 8'b0) begin
            bad++;
            $display("FAIL rmid_async_ctrl: got %b want 00000000",
                     {busy, grant, m_arvalid, m_rready, s0_arready, s1_arready,
                      s0_rvalid, s1_rvalid});
        end
        total++;
        if ({m_araddr, s0_rdata, s1_rdata, s0_rresp, s1_rresp} !== '0) begin
            bad++;
            $display("FAIL rmid_async_data: got %h %h %h want 0", m_araddr, s0_rdata, s1_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        r_stall = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rmid_not_resumed: got busy=%b want 0", busy);
        end
        @(negedge clk);
        set_req(0, 1'b1, 32'd2);
        set_req(1, 1'b1, 32'd3);
        #1;
        total++;
        if (s0_arready !== 1'b1 || s1_arready !== 1'b0) begin
            bad++;
            $display("FAIL rmid_first_grant: got s0=%b s1=%b want 1 0", s0_arready, s1_arready);
        end
        @(negedge clk);
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (s0_rvalid) begin
                seen = 1;
                total++;
                if (s0_rdata !== 32'd10) begin
                    bad++;
                    $display("FAIL rmid_data: got %0d want 10", s0_rdata);
                end
            end
            @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rmid_served: got no s0 rvalid want rvalid");
        end
    endtask

`ifdef AXI_LITE_RD_ARB_TIMEOUT_EN
    task automatic test_timeout;
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        bit          ok, quiet;
        slave_dead = 1'b1;
        single_read(0, 32'd3, d, r, lat, ok, quiet);
        total++;
        if (!ok || d !== 32'd0 || r !== 2'b11) begin
            bad++;
            $display("FAIL timeout_resp: got ok=%0d %0d/%b want 1 0/11", ok, d, r);
        end
        #1;
        total++;
        if (busy !== 1'b0 || m_arvalid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_idle: got busy=%b arvalid=%b want 0 0", busy, m_arvalid);
        end
        slave_dead = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        slave_dead = 1'b0;
        r_stall = 1'b0;
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        s0_araddr = '0;
        s1_araddr = '0;
        s0_rready = 1'b0;
        s1_rready = 1'b0;
        test_reset();
        test_single();
        test_decerr();
        test_round_robin();
        test_hold();
        test_reset_mid();
`ifdef AXI_LITE_RD_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
